// File: rtl/aha_tlx_pkg.sv
// Shared definitions for the TLX training lanes: state encoding and
// pattern geometry.
package aha_tlx_pkg;

    localparam int SEQ_W  = 32;
    localparam int IDX_W  = 5;
    localparam int FILL_W = $clog2(SEQ_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        CHECK  = 2'b10,
        FINISH = 2'b11
    } tlx_state_e;

endpackage

// File: rtl/aha_tlx_rise_pulse.sv
// One-flop rising-edge detector: pulse is high for the single cycle in
// which level is high and was low at the previous clock edge.
module aha_tlx_rise_pulse (
    input  logic CLK,
    input  logic RESETn,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Remember the level seen at the previous edge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) level_q <= 1'b0;
        else         level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/aha_tlx_input_lane.sv
// Receive-side TLX training lane monitor.
// Mission mode passes the PHY bit through; training mode aligns to a
// 32-bit LSB-first pattern, then counts pattern words and bit errors.
// Optional build macro: AHA_TLX_IN_RELOCK_EN -- a completed word that
// contained any bit error drops the lane from CHECK back to SEARCH.
module aha_tlx_input_lane
    import aha_tlx_pkg::*;
#(
    parameter int ERR_W = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             D_IN,
    input  logic             START,
    input  logic             CLEAR,
    input  logic [31:0]      SEQUENCE,
    input  logic [31:0]      LENGTH,
    input  logic             AUTO_STOP,
    input  logic             MODE,
    output logic             D_OUT,
    output logic             ACTIVE,
    output logic             LOCKED,
    output logic             DONE,
    output logic [31:0]      WORD_COUNT,
    output logic [ERR_W-1:0] ERR_COUNT
);

    logic              start_pulse;
    logic              clear_pulse;
    tlx_state_e        state;
    tlx_state_e        state_next;
    // Only the 31 most recent bits are stored; the alignment window is
    // completed by the bit arriving this cycle, so lock is taken on the
    // edge that shifts in the last bit of a pattern and the very next bit
    // is checked against SEQUENCE[0].
    logic [SEQ_W-2:0]  sr;
    logic [SEQ_W-1:0]  window;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       word_count;
    logic [ERR_W-1:0]  err_count;
    logic              done_q;
    logic              match;
    logic              mismatch;
    logic              word_end;
    logic              done_w;
    logic              relock_w;
`ifdef AHA_TLX_IN_RELOCK_EN
    logic              word_err;
`endif

    aha_tlx_rise_pulse u_start_edge (
        .CLK    (CLK),
        .RESETn (RESETn),
        .level  (START),
        .pulse  (start_pulse)
    );

    aha_tlx_rise_pulse u_clear_edge (
        .CLK    (CLK),
        .RESETn (RESETn),
        .level  (CLEAR),
        .pulse  (clear_pulse)
    );

    assign window   = {D_IN, sr};
    assign fill_inc = (fill == FILL_W'(SEQ_W)) ? fill : fill + FILL_W'(1);
    assign match    = (fill >= FILL_W'(SEQ_W - 1)) && (window == SEQUENCE);
    assign mismatch = D_IN ^ SEQUENCE[idx];
    assign word_end = (idx == IDX_W'(SEQ_W - 1));
    assign done_w   = (state == CHECK) && AUTO_STOP && (word_count >= LENGTH);
`ifdef AHA_TLX_IN_RELOCK_EN
    assign relock_w = (state == CHECK) && word_end && (word_err | mismatch);
`else
    assign relock_w = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state decode; CLEAR wins over everything, START only from IDLE.
    always_comb begin
        state_next = state;
        if (clear_pulse) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_pulse) state_next = SEARCH;
                SEARCH:  if (match)       state_next = CHECK;
                CHECK: begin
                    if (done_w)        state_next = FINISH;
                    else if (relock_w) state_next = SEARCH;
                end
                FINISH:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Alignment shifter, bit index, counters and sticky DONE.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sr         <= '0;
            fill       <= '0;
            idx        <= '0;
            word_count <= '0;
            err_count  <= '0;
            done_q     <= 1'b0;
`ifdef AHA_TLX_IN_RELOCK_EN
            word_err   <= 1'b0;
`endif
        end else if (clear_pulse) begin
            word_count <= '0;
            err_count  <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        sr         <= '0;
                        fill       <= '0;
                        idx        <= '0;
                        word_count <= '0;
                        err_count  <= '0;
                        done_q     <= 1'b0;
`ifdef AHA_TLX_IN_RELOCK_EN
                        word_err   <= 1'b0;
`endif
                    end
                end
                SEARCH: begin
                    sr   <= window[SEQ_W-1:1];
                    fill <= fill_inc;
                    if (match) begin
                        idx        <= '0;
                        word_count <= 32'd1;
`ifdef AHA_TLX_IN_RELOCK_EN
                        word_err   <= 1'b0;
`endif
                    end
                end
                CHECK: begin
                    if (done_w) begin
                        done_q <= 1'b1;
                    end else begin
                        sr   <= window[SEQ_W-1:1];
                        fill <= fill_inc;
                        idx  <= idx + IDX_W'(1);
                        if (mismatch && (err_count != {ERR_W{1'b1}}))
                            err_count <= err_count + ERR_W'(1);
                        if (word_end) begin
                            if (relock_w) word_count <= '0;
                            else          word_count <= word_count + 32'd1;
                        end
`ifdef AHA_TLX_IN_RELOCK_EN
                        word_err <= word_end ? 1'b0 : (word_err | mismatch);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign ACTIVE     = (state == SEARCH) || (state == CHECK);
    assign LOCKED     = (state == CHECK);
    assign DONE       = done_q;
    assign WORD_COUNT = word_count;
    assign ERR_COUNT  = err_count;
    assign D_OUT      = MODE ? 1'b0 : D_IN;

endmodule

// File: tb/tb_aha_tlx_input_lane.sv
// Directed bench for aha_tlx_input_lane: a scenario table for the
// lock/count/finish paths plus hand-written corner-case sequences.
module tb_aha_tlx_input_lane;

    localparam int ERR_W = 16;

    logic             CLK = 1'b0;
    logic             RESETn;
    logic             D_IN;
    logic             START;
    logic             CLEAR;
    logic [31:0]      SEQUENCE;
    logic [31:0]      LENGTH;
    logic             AUTO_STOP;
    logic             MODE;
    logic             D_OUT;
    logic             ACTIVE;
    logic             LOCKED;
    logic             DONE;
    logic [31:0]      WORD_COUNT;
    logic [ERR_W-1:0] ERR_COUNT;

    aha_tlx_input_lane #(.ERR_W(ERR_W)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .D_IN       (D_IN),
        .START      (START),
        .CLEAR      (CLEAR),
        .SEQUENCE   (SEQUENCE),
        .LENGTH     (LENGTH),
        .AUTO_STOP  (AUTO_STOP),
        .MODE       (MODE),
        .D_OUT      (D_OUT),
        .ACTIVE     (ACTIVE),
        .LOCKED     (LOCKED),
        .DONE       (DONE),
        .WORD_COUNT (WORD_COUNT),
        .ERR_COUNT  (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          off;        // stream starts at SEQUENCE[off]
        int          fa;         // stream positions to invert (-1 = none)
        int          fb;
        logic [31:0] len;
        int          lock_bits;  // bits fed until LOCKED
        int          exp_wc;
        int          exp_err;
    } scen_t;

    typedef struct {
        logic mode;
        logic din;
        logic exp_dout;
    } dvec_t;

    int errors = 0;
    int checks = 0;
    int pos;
    int off;
    int fa;
    int fb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive n stream bits, one per clock.
    task automatic feed(input int n);
        logic [4:0] b;
        for (int i = 0; i < n; i++) begin
            b    = 5'((pos + off) % 32);
            D_IN = SEQUENCE[b] ^ ((pos == fa) || (pos == fb));
            pos++;
            tick();
        end
    endtask

    scen_t scen[5];
    dvec_t dvec[4];

    initial begin
        // off, fa, fb, len, lock_bits, exp_wc, exp_err
        scen[0] = '{0,  -1, -1, 32'd4, 32, 4, 0};
        scen[1] = '{7,  -1, -1, 32'd4, 57, 4, 0};
        scen[2] = '{0,  35, 72, 32'd4, 32, 4, 2};
        scen[3] = '{0,  -1, -1, 32'd0, 32, 1, 0};
        scen[4] = '{5,  59, 90, 32'd2, 59, 2, 2};
        dvec[0] = '{1'b0, 1'b0, 1'b0};
        dvec[1] = '{1'b0, 1'b1, 1'b1};
        dvec[2] = '{1'b1, 1'b1, 1'b0};
        dvec[3] = '{1'b1, 1'b0, 1'b0};

        RESETn = 1'b0; D_IN = 1'b0; START = 1'b0; CLEAR = 1'b0;
        SEQUENCE = 32'hA5C3_0F96; LENGTH = 32'd4; AUTO_STOP = 1'b1; MODE = 1'b1;
        pos = 0; off = 0; fa = -1; fb = -1;
        tick(); tick();
        chk("rst_active", {31'd0, ACTIVE}, 32'd0);
        chk("rst_locked", {31'd0, LOCKED}, 32'd0);
        chk("rst_done",   {31'd0, DONE},   32'd0);
        chk("rst_wc",     WORD_COUNT,      32'd0);
        chk("rst_err",    32'(ERR_COUNT),  32'd0);
        RESETn = 1'b1;
        tick();

        // Pass-through / forced-zero output.
        for (int i = 0; i < 4; i++) begin
            MODE = dvec[i].mode; D_IN = dvec[i].din;
            #1;
            chk($sformatf("dout_%0d", i), {31'd0, D_OUT}, {31'd0, dvec[i].exp_dout});
        end
        MODE = 1'b1;
        tick();

        // Lock / count / finish scenarios.
        for (int s = 0; s < 5; s++) begin
            pos = 0; off = scen[s].off; fa = scen[s].fa; fb = scen[s].fb;
            LENGTH = scen[s].len; AUTO_STOP = 1'b1;
            START = 1'b1;
            tick();
            chk($sformatf("s%0d_active", s), {31'd0, ACTIVE}, 32'd1);
            feed(scen[s].lock_bits - 1);
            chk($sformatf("s%0d_prelock", s), {31'd0, LOCKED}, 32'd0);
            feed(1);
            chk($sformatf("s%0d_locked", s), {31'd0, LOCKED}, 32'd1);
            chk($sformatf("s%0d_wc1", s), WORD_COUNT, 32'd1);
            feed((scen[s].exp_wc - 1) * 32);
            chk($sformatf("s%0d_wc", s), WORD_COUNT, 32'(scen[s].exp_wc));
            chk($sformatf("s%0d_notdone", s), {31'd0, DONE}, 32'd0);
            feed(1);
            chk($sformatf("s%0d_done", s), {31'd0, DONE}, 32'd1);
            chk($sformatf("s%0d_inactive", s), {30'd0, ACTIVE, LOCKED}, 32'd0);
            chk($sformatf("s%0d_err", s), 32'(ERR_COUNT), 32'(scen[s].exp_err));
            feed(2);
            chk($sformatf("s%0d_hold_wc", s), WORD_COUNT, 32'(scen[s].exp_wc));
            chk($sformatf("s%0d_idle", s), {31'd0, ACTIVE}, 32'd0);
            START = 1'b0;
            tick();
        end

        // Restart clears DONE and counters.
        START = 1'b1;
        tick();
        chk("restart_done", {31'd0, DONE}, 32'd0);
        chk("restart_wc", WORD_COUNT, 32'd0);
        START = 1'b0;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        tick();

        // Free-running: 100 words, no DONE, then CLEAR.
        pos = 0; off = 0; fa = -1; fb = -1; AUTO_STOP = 1'b0; LENGTH = 32'd4;
        START = 1'b1;
        tick();
        feed(32 * 100);
        chk("free_wc", WORD_COUNT, 32'd100);
        chk("free_done", {31'd0, DONE}, 32'd0);
        chk("free_locked", {31'd0, LOCKED}, 32'd1);
        CLEAR = 1'b1;
        tick();
        chk("clear_active", {31'd0, ACTIVE}, 32'd0);
        chk("clear_wc", WORD_COUNT, 32'd0);
        chk("clear_err", 32'(ERR_COUNT), 32'd0);
        START = 1'b0; CLEAR = 1'b0;
        tick();

        // START and CLEAR rising on the same edge.
        START = 1'b1; CLEAR = 1'b1;
        tick();
        chk("startclear_idle", {31'd0, ACTIVE}, 32'd0);
        tick();
        chk("startclear_idle2", {31'd0, ACTIVE}, 32'd0);
        START = 1'b0; CLEAR = 1'b0;
        tick();

        // Fill gate with an all-zero pattern, then START during CHECK.
        SEQUENCE = 32'h0; D_IN = 1'b0; AUTO_STOP = 1'b1; LENGTH = 32'd10;
        pos = 0; off = 0;
        START = 1'b1;
        tick();
        feed(31);
        chk("gate_prelock", {31'd0, LOCKED}, 32'd0);
        feed(1);
        chk("gate_locked", {31'd0, LOCKED}, 32'd1);
        START = 1'b0;
        feed(1);
        START = 1'b1;
        feed(1);
        chk("restart_in_check_locked", {31'd0, LOCKED}, 32'd1);
        chk("restart_in_check_wc", WORD_COUNT, 32'd1);
        feed(5);

        // Asynchronous reset mid-CHECK.
        RESETn = 1'b0;
        #1;
        chk("arst_active", {30'd0, ACTIVE, LOCKED}, 32'd0);
        chk("arst_wc", WORD_COUNT, 32'd0);
        chk("arst_done", {31'd0, DONE}, 32'd0);
        START = 1'b0;
        tick();
        RESETn = 1'b1;
        tick();
        chk("arst_still_idle", {31'd0, ACTIVE}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
